// File: rtl/shifter_pkg.sv
// Shared constants for the 16-bit shifter and its multi-cycle sequencer.
package shifter_pkg;

  localparam int DATA_W = 16;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Shifter control encodings
  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_ROT   = 1'b1;

endpackage

// File: rtl/shifter_16b_top.sv
// Combinational 16-bit logarithmic shifter/rotator, amount 0..15.
// Four stages; stage gi moves the word by 2**gi when shift[gi] is set.
module shifter_16b_top
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [3:0]        shift,
  input  logic              dir,
  input  logic              rot,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] stage [0:4];

  assign stage[0] = x;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      localparam int N = 1 << gi;
      logic [DATA_W-1:0] shl;
      logic [DATA_W-1:0] shr;
      logic [DATA_W-1:0] rol;
      logic [DATA_W-1:0] ror;
      logic [DATA_W-1:0] moved;

      assign shl = stage[gi] << N;
      assign shr = stage[gi] >> N;
      assign rol = shl | (stage[gi] >> (DATA_W - N));
      assign ror = shr | (stage[gi] << (DATA_W - N));

      // Select the moved word for this stage from direction and mode
      always_comb begin
        moved = shl;
        if (dir == DIR_RIGHT) moved = (rot == MODE_ROT) ? ror : shr;
        else                  moved = (rot == MODE_ROT) ? rol : shl;
      end

      assign stage[gi+1] = shift[gi] ? moved : stage[gi];
    end
  endgenerate

  assign y = stage[4];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer: applies a 0..63 shift/rotate in chunks of at most
// MAX_STEP through one shared combinational shifter, valid/ready on both ends.
module shift_seq_ctrl
  import shifter_pkg::*;
#(
  parameter int AMT_W    = 6,
  parameter int MAX_STEP = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  input  logic              in_rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] acc_reg;
  logic [AMT_W-1:0]  remaining_reg;
  logic              dir_reg;
  logic              rot_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic              accept;
  logic [AMT_W-1:0]  step;
  logic [AMT_W-1:0]  rem_after;
  logic [DATA_W-1:0] shift_out;

  assign accept    = in_valid && in_ready;
  assign step      = (remaining_reg > MAX_STEP_A) ? MAX_STEP_A : remaining_reg;
  assign rem_after = remaining_reg - step;

  shifter_16b_top u_shifter (
    .x     (acc_reg),
    .shift (step[3:0]),
    .dir   (dir_reg),
    .rot   (rot_reg),
    .y     (shift_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; DONE can hand straight over to a new request
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_BUSY;
      S_BUSY: if (rem_after == '0) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = accept ? S_BUSY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
    out_valid = (state_reg == S_DONE);
    busy      = (state_reg == S_BUSY);
  end

  // Datapath: capture request, step the accumulator, latch result on finish
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      remaining_reg <= '0;
      dir_reg       <= DIR_LEFT;
      rot_reg       <= MODE_SHIFT;
      out_data_reg  <= '0;
    end else if (accept) begin
      acc_reg       <= in_data;
      remaining_reg <= in_amt;
      dir_reg       <= in_dir;
      rot_reg       <= in_rot;
    end else if (state_reg == S_BUSY) begin
      acc_reg       <= shift_out;
      remaining_reg <= rem_after;
      if (rem_after == '0) out_data_reg <= shift_out;
    end
  end

  assign out_data = out_data_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with hand-computed expected results.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  in_amt;
  logic        in_dir;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_rot    (in_rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s: %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until the accepting clock edge
  task automatic send(input logic [15:0] d, input logic [5:0] a, input logic dr, input logic rt);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    in_rot   = rt;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after acceptance; counts BUSY cycles until out_valid
  task automatic wait_done(input string tag, input logic [15:0] exp_data, input int exp_busy);
    int nb = 0;
    int n  = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      if (busy) nb++;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({tag, "_latency"}, 32'(n), 32'(exp_busy + 1));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_dir = 1'b0; in_rot = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Basic single-chunk shift
    send(16'h0001, 6'd3, 1'b0, 1'b0);  wait_done("shl3", 16'h0008, 1);  consume();
    // Two-chunk rotate left: 20 mod 16 = 4
    send(16'h8001, 6'd20, 1'b0, 1'b1); wait_done("rol20", 16'h0018, 2); consume();
    // Rotate right 17 mod 16 = 1
    send(16'h0001, 6'd17, 1'b1, 1'b1); wait_done("ror17", 16'h8000, 2); consume();
    // Long logical shift clears the word but runs all three chunks
    send(16'hFFFF, 6'd40, 1'b0, 1'b0); wait_done("shl40", 16'h0000, 3); consume();
    // Zero amount in both modes
    send(16'hA5A5, 6'd0, 1'b0, 1'b0);  wait_done("amt0_shift", 16'hA5A5, 1); consume();
    send(16'hA5A5, 6'd0, 1'b1, 1'b1);  wait_done("amt0_rot", 16'hA5A5, 1);   consume();
    // Right logical shift over exactly one full chunk
    send(16'hF000, 6'd15, 1'b1, 1'b0); wait_done("shr15", 16'h0001, 1); consume();

    // Backpressure in DONE, then back-to-back accept
    send(16'h00FF, 6'd4, 1'b0, 1'b0);  wait_done("hold", 16'h0FF0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'h0FF0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_amt    = 6'd4;
    in_dir    = 1'b0;
    in_rot    = 1'b1;
    #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_out_valid", 32'(out_valid), 32'd0);
    wait_done("b2b", 16'h2341, 1);
    consume();

    // Reset during the second BUSY cycle discards the operation
    send(16'hFFFF, 6'd40, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("mid_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'h0F00, 6'd8, 1'b1, 1'b1);  wait_done("post_rst", 16'h000F, 1); consume();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

endmodule
